// File: rtl/fc_rd_resp.sv
// rtl/fc_rd_resp.sv - read responder: AR queue, SRAM beat engine, registered R channel
// Optional R-channel backpressure with skid buffer: define FC_RD_RESP_RREADY_EN.
`timescale 1ns/1ps
module fc_rd_resp #(
   parameter int ADDR_W   = 28,
   parameter int DATA_W   = 32,
   parameter int AQ_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              NrcBus_arvalid,
   input  logic [3:0]        NrcBus_aruserid,
   input  logic [3:0]        NrcBus_arlen,
   input  logic              NrcBus_aruserap,
   input  logic [ADDR_W-1:0] NrcBus_araddr,
   output logic              BusNrc_arready,
`ifdef FC_RD_RESP_RREADY_EN
   input  logic              BusNrc_rready,
`endif
   output logic              BusNrc_rvalid,
   output logic              BusNrc_rlast,
   output logic [3:0]        BusNrc_rid,
   output logic [DATA_W-1:0] BusNrc_rdata,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              busy
);

   localparam int QP_W = $clog2(AQ_DEPTH);
   localparam logic [QP_W:0] Q_FULL = (QP_W+1)'(AQ_DEPTH);

   typedef enum logic {IDLE, ISSUE} state_t;

   // AR queue
   logic [3:0]        q_id   [AQ_DEPTH];
   logic [3:0]        q_len  [AQ_DEPTH];
   logic              q_ap   [AQ_DEPTH];
   logic [ADDR_W-1:0] q_addr [AQ_DEPTH];
   logic [QP_W-1:0]   q_wr, q_rd;
   logic [QP_W:0]     q_cnt;
   logic              q_empty, q_full, push, pop, rdy_q;

   assign q_empty        = (q_cnt == '0);
   assign q_full         = (q_cnt == Q_FULL);
   assign BusNrc_arready = !q_full && rdy_q;
   assign push           = NrcBus_arvalid && BusNrc_arready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_q <= 1'b0;
         q_wr  <= '0;
         q_rd  <= '0;
         q_cnt <= '0;
      end else begin
         rdy_q <= 1'b1;
         if (push) q_wr <= q_wr + 1'b1;
         if (pop)  q_rd <= q_rd + 1'b1;
         case ({push, pop})
            2'b10:   q_cnt <= q_cnt + 1'b1;
            2'b01:   q_cnt <= q_cnt - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_id[q_wr]   <= NrcBus_aruserid;
         q_len[q_wr]  <= NrcBus_arlen;
         q_ap[q_wr]   <= NrcBus_aruserap;
         q_addr[q_wr] <= NrcBus_araddr;
      end
   end

   // Beat engine
   state_t            state, state_d;
   logic [ADDR_W-1:0] addr_c;
   logic [3:0]        beats_left, id_c;
   logic              ap_c, load, issue, stall;
   logic              s1_valid, s1_last;
   logic [3:0]        s1_id;

   always_comb begin
      state_d = state;
      pop     = 1'b0;
      load    = 1'b0;
      issue   = 1'b0;
      case (state)
         IDLE: begin
            if (!q_empty) begin
               pop     = 1'b1;
               load    = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (!stall) begin
               issue = 1'b1;
               if (beats_left == 4'd0) begin
                  if (!q_empty) begin
                     pop  = 1'b1;
                     load = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         addr_c     <= '0;
         beats_left <= '0;
         id_c       <= '0;
         ap_c       <= 1'b0;
         s1_valid   <= 1'b0;
         s1_last    <= 1'b0;
         s1_id      <= '0;
      end else begin
         state <= state_d;
         if (load) begin
            addr_c     <= q_addr[q_rd];
            beats_left <= q_len[q_rd];
            id_c       <= q_id[q_rd];
            ap_c       <= q_ap[q_rd];
         end else if (issue) begin
            if (ap_c) addr_c <= addr_c + 1'b1;
            beats_left <= beats_left - 1'b1;
         end
         // Tag rides alongside the SRAM read so it lines up with mem_rd_data
         s1_valid <= issue;
         s1_last  <= (beats_left == 4'd0);
         s1_id    <= id_c;
      end
   end

   assign mem_rd_en   = issue;
   assign mem_rd_addr = addr_c;

`ifdef FC_RD_RESP_RREADY_EN
   // Skid buffer: out register plus two entries covers every read already issued
   localparam int SK_W = DATA_W + 5;
   logic [SK_W-1:0] sk_mem [2];
   logic            sk_wr, sk_rd, sk_has, sk_push, sk_pop, out_load, src_valid;
   logic [1:0]      sk_cnt;
   logic [2:0]      occ;
   logic [SK_W-1:0] src;

   assign occ       = 3'(s1_valid) + 3'(sk_cnt) + 3'(BusNrc_rvalid);
   assign stall     = (occ > 3'd2);
   assign sk_has    = (sk_cnt != 2'd0);
   assign out_load  = !BusNrc_rvalid || BusNrc_rready;
   assign sk_push   = s1_valid && (sk_has || !out_load);
   assign sk_pop    = out_load && sk_has;
   assign src       = sk_has ? sk_mem[sk_rd] : {s1_id, s1_last, mem_rd_data};
   assign src_valid = sk_has || s1_valid;

   always_ff @(posedge clk) begin
      if (sk_push) sk_mem[sk_wr] <= {s1_id, s1_last, mem_rd_data};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sk_wr         <= 1'b0;
         sk_rd         <= 1'b0;
         sk_cnt        <= 2'd0;
         BusNrc_rvalid <= 1'b0;
         BusNrc_rlast  <= 1'b0;
         BusNrc_rid    <= '0;
         BusNrc_rdata  <= '0;
      end else begin
         if (sk_push) sk_wr <= ~sk_wr;
         if (sk_pop)  sk_rd <= ~sk_rd;
         case ({sk_push, sk_pop})
            2'b10:   sk_cnt <= sk_cnt + 1'b1;
            2'b01:   sk_cnt <= sk_cnt - 1'b1;
            default: ;
         endcase
         if (out_load) begin
            BusNrc_rvalid <= src_valid;
            BusNrc_rlast  <= src_valid && src[DATA_W];
            if (src_valid) begin
               BusNrc_rid   <= src[DATA_W+4:DATA_W+1];
               BusNrc_rdata <= src[DATA_W-1:0];
            end
         end
      end
   end

   assign busy = !q_empty || (state == ISSUE) || s1_valid || BusNrc_rvalid || sk_has;
`else
   assign stall = 1'b0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         BusNrc_rvalid <= 1'b0;
         BusNrc_rlast  <= 1'b0;
         BusNrc_rid    <= '0;
         BusNrc_rdata  <= '0;
      end else begin
         BusNrc_rvalid <= s1_valid;
         BusNrc_rlast  <= s1_valid && s1_last;
         if (s1_valid) begin
            BusNrc_rid   <= s1_id;
            BusNrc_rdata <= mem_rd_data;
         end
      end
   end

   assign busy = !q_empty || (state == ISSUE) || s1_valid || BusNrc_rvalid;
`endif

endmodule

// File: tb/tb_fc_rd_resp.sv
// tb/tb_fc_rd_resp.sv - directed self-checking bench for fc_rd_resp
`timescale 1ns/1ps
module tb_fc_rd_resp;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        NrcBus_arvalid = 1'b0;
   logic [3:0]  NrcBus_aruserid = '0;
   logic [3:0]  NrcBus_arlen = '0;
   logic        NrcBus_aruserap = 1'b0;
   logic [27:0] NrcBus_araddr = '0;
   logic        BusNrc_arready, BusNrc_rvalid, BusNrc_rlast;
   logic [3:0]  BusNrc_rid;
   logic [31:0] BusNrc_rdata;
   logic        mem_rd_en;
   logic [27:0] mem_rd_addr;
   logic [31:0] mem_rd_data = '0;
   logic        busy;
   logic        rready = 1'b1;

   always #5 clk = ~clk;

   fc_rd_resp dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .NrcBus_arvalid  (NrcBus_arvalid),
      .NrcBus_aruserid (NrcBus_aruserid),
      .NrcBus_arlen    (NrcBus_arlen),
      .NrcBus_aruserap (NrcBus_aruserap),
      .NrcBus_araddr   (NrcBus_araddr),
      .BusNrc_arready  (BusNrc_arready),
`ifdef FC_RD_RESP_RREADY_EN
      .BusNrc_rready   (rready),
`endif
      .BusNrc_rvalid   (BusNrc_rvalid),
      .BusNrc_rlast    (BusNrc_rlast),
      .BusNrc_rid      (BusNrc_rid),
      .BusNrc_rdata    (BusNrc_rdata),
      .mem_rd_en       (mem_rd_en),
      .mem_rd_addr     (mem_rd_addr),
      .mem_rd_data     (mem_rd_data),
      .busy            (busy)
   );

   function automatic logic [31:0] mem_val(input logic [27:0] a);
      if (a == 28'h10) return 32'hA5A5A5A5;
      if (a == 28'h20) return 32'hC0DE0020;
      return {4'h0, a};
   endfunction

   always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem_val(mem_rd_addr);

   typedef struct {
      logic [3:0]  id;
      logic        last;
      logic [31:0] data;
      int          cyc;
   } beat_t;

   int          cyc = 0;
   beat_t       beats[$];
   beat_t       exp_b[$];
   logic [27:0] addrs[$];
   logic [27:0] exp_a[$];
   int          total = 0, passed = 0, fails = 0;
   logic        pend = 1'b0;
   logic [37:0] held = '0;
   int          stab_err = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Observation point sits mid-low-phase, clear of both clock edges
   always @(negedge clk) begin
      #2;
      if (mem_rd_en) addrs.push_back(mem_rd_addr);
      if (BusNrc_rvalid && rready)
         beats.push_back('{BusNrc_rid, BusNrc_rlast, BusNrc_rdata, cyc});
      if (pend && ({BusNrc_rvalid, BusNrc_rid, BusNrc_rlast, BusNrc_rdata} !== held)) stab_err++;
      pend = BusNrc_rvalid && !rready;
      held = {BusNrc_rvalid, BusNrc_rid, BusNrc_rlast, BusNrc_rdata};
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_req(input logic [3:0] id, input logic [3:0] len, input logic ap,
                         input logic [27:0] addr, output int waited);
      NrcBus_arvalid  = 1'b1;
      NrcBus_aruserid = id;
      NrcBus_arlen    = len;
      NrcBus_aruserap = ap;
      NrcBus_araddr   = addr;
      waited = 0;
      while (!BusNrc_arready && waited < 40) begin
         tick();
         waited++;
      end
      chk("ar_accept", BusNrc_arready, 1);
      tick();
      NrcBus_arvalid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      tick();
      while (busy && n < 300) begin
         tick();
         n++;
      end
      chk({tag, "_idle"}, busy, 0);
      tick();
   endtask

   task automatic add_burst(input logic [3:0] id, input logic [3:0] len, input logic ap,
                            input logic [27:0] addr);
      for (int k = 0; k <= int'(len); k++) begin
         logic [27:0] a;
         a = ap ? addr + 28'(k) : addr;
         exp_a.push_back(a);
         exp_b.push_back('{id, (k == int'(len)), mem_val(a), 0});
      end
   endtask

   task automatic cmp_all(input string tag, input bit gapless);
      chk({tag, "_nbeats"}, beats.size(), exp_b.size());
      for (int i = 0; i < exp_b.size() && i < beats.size(); i++) begin
         chk($sformatf("%s_beat%0d", tag, i), {beats[i].id, beats[i].last, beats[i].data},
             {exp_b[i].id, exp_b[i].last, exp_b[i].data});
         if (gapless && i > 0)
            chk($sformatf("%s_gap%0d", tag, i), beats[i].cyc - beats[i-1].cyc, 1);
      end
      chk({tag, "_naddr"}, addrs.size(), exp_a.size());
      for (int i = 0; i < exp_a.size() && i < addrs.size(); i++)
         chk($sformatf("%s_addr%0d", tag, i), addrs[i], exp_a[i]);
      beats.delete();
      exp_b.delete();
      addrs.delete();
      exp_a.delete();
   endtask

   initial begin
      int w, n;

      // Reset state and arready coming up one cycle after release
      tick();
      tick();
      chk("rst_outs", {BusNrc_arready, BusNrc_rvalid, BusNrc_rlast, BusNrc_rid, BusNrc_rdata,
                       mem_rd_en, busy}, 0);
      chk("rst_addr", mem_rd_addr, 0);
      rst_n = 1'b1;
      chk("arready_at_release", BusNrc_arready, 0);
      tick();
      chk("arready_after_release", BusNrc_arready, 1);

      // Single beat, latency three cycles from handshake
      do_req(4'd9, 4'd0, 1'b1, 28'h10, w);
      n = 0;
      while (!BusNrc_rvalid && n < 10) begin
         tick();
         n++;
      end
      chk("single_latency", n, 3);
      chk("single_rbeat", {BusNrc_rvalid, BusNrc_rlast, BusNrc_rid, BusNrc_rdata},
          {1'b1, 1'b1, 4'd9, 32'hA5A5A5A5});
      tick();
      chk("single_rvalid_drop", BusNrc_rvalid, 0);
      add_burst(4'd9, 4'd0, 1'b1, 28'h10);
      wait_idle("single");
      cmp_all("single", 1'b1);

      // 16-beat incrementing burst
      do_req(4'd3, 4'd15, 1'b1, 28'h100, w);
      add_burst(4'd3, 4'd15, 1'b1, 28'h100);
      wait_idle("inc16");
      cmp_all("inc16", 1'b1);

      // Fixed address
      do_req(4'd5, 4'd3, 1'b0, 28'h20, w);
      add_burst(4'd5, 4'd3, 1'b0, 28'h20);
      wait_idle("fixed");
      cmp_all("fixed", 1'b1);

      // Queue fill behind a long burst; the sixth request waits for the first tail pop
      do_req(4'd1, 4'd15, 1'b1, 28'h200, w);
      do_req(4'd2, 4'd1, 1'b1, 28'h300, w);
      do_req(4'd3, 4'd1, 1'b1, 28'h310, w);
      do_req(4'd4, 4'd1, 1'b1, 28'h320, w);
      do_req(4'd5, 4'd1, 1'b1, 28'h330, w);
      chk("qfull_arready", BusNrc_arready, 0);
      do_req(4'd6, 4'd1, 1'b1, 28'h340, w);
      chk("qfull_wait", w, 13);
      add_burst(4'd1, 4'd15, 1'b1, 28'h200);
      add_burst(4'd2, 4'd1, 1'b1, 28'h300);
      add_burst(4'd3, 4'd1, 1'b1, 28'h310);
      add_burst(4'd4, 4'd1, 1'b1, 28'h320);
      add_burst(4'd5, 4'd1, 1'b1, 28'h330);
      add_burst(4'd6, 4'd1, 1'b1, 28'h340);
      wait_idle("qfull");
      cmp_all("qfull", 1'b1);

      // Address wrap at the top of the space
      do_req(4'd7, 4'd3, 1'b1, 28'hFFFFFFE, w);
      add_burst(4'd7, 4'd3, 1'b1, 28'hFFFFFFE);
      wait_idle("wrap");
      cmp_all("wrap", 1'b1);

      // Reset after beat 2 of a repeat burst
      do_req(4'd8, 4'd3, 1'b1, 28'hFFFFFFE, w);
      n = 0;
      while (!BusNrc_rvalid && n < 10) begin
         tick();
         n++;
      end
      tick();
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_outs", {BusNrc_arready, BusNrc_rvalid, BusNrc_rlast, BusNrc_rid, BusNrc_rdata,
                          mem_rd_en, busy}, 0);
      chk("midrst_addr", mem_rd_addr, 0);
      tick();
      tick();
      rst_n = 1'b1;
      chk("midrst_arready_release", BusNrc_arready, 0);
      tick();
      chk("midrst_arready_after", BusNrc_arready, 1);
      chk("midrst_queue_empty", busy, 0);
      for (int k = 0; k < 6; k++) tick();
      add_burst(4'd8, 4'd3, 1'b1, 28'hFFFFFFE);
      void'(exp_b.pop_back());
      void'(exp_b.pop_back());
      cmp_all("midrst", 1'b1);

`ifdef FC_RD_RESP_RREADY_EN
      // Backpressure with rready pattern 1,0,0,1
      do_req(4'hA, 4'd7, 1'b1, 28'h40, w);
      for (int k = 0; k < 40; k++) begin
         rready = ((k % 4) == 0) || ((k % 4) == 3);
         tick();
      end
      rready = 1'b1;
      add_burst(4'hA, 4'd7, 1'b1, 28'h40);
      wait_idle("rready");
      chk("rready_stable", stab_err, 0);
      cmp_all("rready", 1'b0);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
